// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register with stall, flush, bubble counter; optional load-use detect via ID_EX_HAZARD_DETECT_EN
module id_ex_latch #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ctlwb_in,
  input  logic [2:0]      ctlm_in,
  input  logic [3:0]      ctlex_in,
  input  logic [DW-1:0]   npc_in,
  input  logic [DW-1:0]   readdat1_in,
  input  logic [DW-1:0]   readdat2_in,
  input  logic [DW-1:0]   signext_in,
  input  logic [4:0]      rs_in,
  input  logic [4:0]      rt_in,
  input  logic [4:0]      rd_in,
  input  logic            valid_in,
  input  logic            stall,
  input  logic            flush,
  output logic [1:0]      wb_out,
  output logic [2:0]      m_out,
  output logic [3:0]      ex_out,
  output logic [DW-1:0]   npc_out,
  output logic [DW-1:0]   readdat1_out,
  output logic [DW-1:0]   readdat2_out,
  output logic [DW-1:0]   signext_out,
  output logic [4:0]      rs_out,
  output logic [4:0]      rt_out,
  output logic [4:0]      rd_out,
  output logic            valid_out,
  output logic            hazard_stall,
  output logic [CNTW-1:0] bubble_cnt
);
  logic hazard;
  logic bubble;
`ifdef ID_EX_HAZARD_DETECT_EN
  // m_out[1] is MemRead: a load in EX whose target feeds the decode instruction
  assign hazard = valid_out & m_out[1] & valid_in & (rt_out == rs_in | rt_out == rt_in);
`else
  assign hazard = 1'b0;
`endif
  assign hazard_stall = hazard;
  assign bubble = flush | hazard;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_out       <= '0;
      m_out        <= '0;
      ex_out       <= '0;
      npc_out      <= '0;
      readdat1_out <= '0;
      readdat2_out <= '0;
      signext_out  <= '0;
      rs_out       <= '0;
      rt_out       <= '0;
      rd_out       <= '0;
      valid_out    <= 1'b0;
      bubble_cnt   <= '0;
    end else if (bubble | ~stall) begin
      wb_out       <= bubble ? '0 : ctlwb_in;
      m_out        <= bubble ? '0 : ctlm_in;
      ex_out       <= bubble ? '0 : ctlex_in;
      valid_out    <= bubble ? 1'b0 : valid_in;
      npc_out      <= npc_in;
      readdat1_out <= readdat1_in;
      readdat2_out <= readdat2_in;
      signext_out  <= signext_in;
      rs_out       <= rs_in;
      rt_out       <= rt_in;
      rd_out       <= rd_in;
      if (bubble && ~&bubble_cnt) bubble_cnt <= bubble_cnt + CNTW'(1);
    end
endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: directed stimulus against a behavioural model of the ID/EX latch, plus pinned literal checks
module tb_id_ex_latch;
  localparam int DW = 32;
  localparam int CNTW = 16;
  localparam int CMAX = (1 << CNTW) - 1;
`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [1:0] ctlwb_in = 0;
  logic [2:0] ctlm_in = 0;
  logic [3:0] ctlex_in = 0;
  logic [DW-1:0] npc_in = 0, readdat1_in = 0, readdat2_in = 0, signext_in = 0;
  logic [4:0] rs_in = 0, rt_in = 0, rd_in = 0;
  logic valid_in = 0, stall = 0, flush = 0;
  logic [1:0] wb_out;
  logic [2:0] m_out;
  logic [3:0] ex_out;
  logic [DW-1:0] npc_out, readdat1_out, readdat2_out, signext_out;
  logic [4:0] rs_out, rt_out, rd_out;
  logic valid_out, hazard_stall;
  logic [CNTW-1:0] bubble_cnt;
  int n_tests = 0, n_fail = 0;

  id_ex_latch #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .readdat1_in(readdat1_in), .readdat2_in(readdat2_in), .signext_in(signext_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .valid_in(valid_in), .stall(stall), .flush(flush),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out), .npc_out(npc_out),
    .readdat1_out(readdat1_out), .readdat2_out(readdat2_out), .signext_out(signext_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .valid_out(valid_out),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // model of what EX must see: one stored instruction record plus a bubble tally
  logic [1:0] e_wb;
  logic [2:0] e_m;
  logic [3:0] e_ex;
  logic [DW-1:0] e_npc, e_r1, e_r2, e_se;
  logic [4:0] e_rs, e_rt, e_rd;
  logic e_v;
  int e_cnt;

  function automatic bit load_use();
    return HZ && e_v && e_m[1] && valid_in && (e_rt == rs_in || e_rt == rt_in);
  endfunction

  task automatic take_data();
    e_npc = npc_in; e_r1 = readdat1_in; e_r2 = readdat2_in; e_se = signext_in;
    e_rs = rs_in; e_rt = rt_in; e_rd = rd_in;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_wb = 0; e_m = 0; e_ex = 0; e_npc = 0; e_r1 = 0; e_r2 = 0; e_se = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_v = 0; e_cnt = 0;
    end else if (flush || load_use()) begin
      take_data();
      e_wb = 0; e_m = 0; e_ex = 0; e_v = 0;
      e_cnt = (e_cnt < CMAX) ? e_cnt + 1 : CMAX;
    end else if (!stall) begin
      take_data();
      e_wb = ctlwb_in; e_m = ctlm_in; e_ex = ctlex_in; e_v = valid_in;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("wb_out", 64'(wb_out), 64'(e_wb));
    chk("m_out", 64'(m_out), 64'(e_m));
    chk("ex_out", 64'(ex_out), 64'(e_ex));
    chk("valid_out", 64'(valid_out), 64'(e_v));
    chk("npc_out", 64'(npc_out), 64'(e_npc));
    chk("readdat1_out", 64'(readdat1_out), 64'(e_r1));
    chk("readdat2_out", 64'(readdat2_out), 64'(e_r2));
    chk("signext_out", 64'(signext_out), 64'(e_se));
    chk("rs_out", 64'(rs_out), 64'(e_rs));
    chk("rt_out", 64'(rt_out), 64'(e_rt));
    chk("rd_out", 64'(rd_out), 64'(e_rd));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(e_cnt));
    chk("hazard_stall", 64'(hazard_stall), 64'(load_use()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                       input logic [DW-1:0] r1, input logic [4:0] rs, input logic [4:0] rt,
                       input logic v);
    ctlwb_in = wb; ctlm_in = m; ctlex_in = ex; readdat1_in = r1;
    readdat2_in = r1 ^ 32'hA5A5_0000; signext_in = r1 + 32'h100; npc_in = r1 + 32'h4;
    rs_in = rs; rt_in = rt; rd_in = rs ^ rt; valid_in = v;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    chk("reset valid", 64'(valid_out), 64'd0);
    chk("reset cnt", 64'(bubble_cnt), 64'd0);
    // R-type load
    drive(2'b10, 3'b000, 4'b1100, 32'h11, 5'd1, 5'd2, 1'b1);
    tick();
    chk("rtype wb", 64'(wb_out), 64'h2);
    chk("rtype ex", 64'(ex_out), 64'hC);
    chk("rtype rd1", 64'(readdat1_out), 64'h11);
    chk("rtype valid", 64'(valid_out), 64'd1);
    // lw loaded, then held through three stall cycles with changing inputs
    drive(2'b11, 3'b010, 4'b0001, 32'h22, 5'd1, 5'd9, 1'b1);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(2'(i), 3'(i + 1), 4'(i + 5), 32'h300 + 32'(i), 5'(i + 1), 5'(i + 4), 1'b1);
      tick();
    end
    chk("stall wb", 64'(wb_out), 64'h3);
    chk("stall m", 64'(m_out), 64'h2);
    chk("stall ex", 64'(ex_out), 64'h1);
    chk("stall rd1", 64'(readdat1_out), 64'h22);
    chk("stall cnt", 64'(bubble_cnt), 64'd0);
    // flush and stall together
    flush = 1;
    tick();
    flush = 0; stall = 0;
    chk("flush wb", 64'(wb_out), 64'd0);
    chk("flush m", 64'(m_out), 64'd0);
    chk("flush valid", 64'(valid_out), 64'd0);
    chk("flush cnt", 64'(bubble_cnt), 64'd1);
    // asynchronous reset mid-cycle
    drive(2'b10, 3'b001, 4'b1010, 32'h55, 5'd4, 5'd5, 1'b1);
    tick();
    #2 rst = 1;
    #1;
    chk("async valid", 64'(valid_out), 64'd0);
    chk("async wb", 64'(wb_out), 64'd0);
    chk("async npc", 64'(npc_out), 64'd0);
    chk("async cnt", 64'(bubble_cnt), 64'd0);
    tick();
    rst = 0;
    // load-use: lw with rt=8 in EX, decode reads rs=8
    drive(2'b11, 3'b010, 4'b0001, 32'h66, 5'd2, 5'd8, 1'b1);
    tick();
    drive(2'b10, 3'b000, 4'b1100, 32'h77, 5'd8, 5'd3, 1'b1);
    #1;
    chk("lu hazard_stall", 64'(hazard_stall), 64'(HZ));
    tick();
    chk("lu valid", 64'(valid_out), 64'(!HZ));
    chk("lu cnt", 64'(bubble_cnt), 64'(HZ));
    chk("lu hazard drop", 64'(hazard_stall), 64'd0);
    tick();
    chk("lu load valid", 64'(valid_out), 64'd1);
    chk("lu load rs", 64'(rs_out), 64'd8);
    chk("lu load ex", 64'(ex_out), 64'hC);
    // saturation: 2^CNTW+2 flushes
    flush = 1;
    for (int i = 0; i < (1 << CNTW) + 2; i++) tick();
    chk("sat cnt", 64'(bubble_cnt), 64'(CMAX));
    flush = 0;
    tick();
    chk("sat hold", 64'(bubble_cnt), 64'(CMAX));
    chk("sat load valid", 64'(valid_out), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- ID/EX pipeline register of the 5-stage MIPS datapath, directly downstream of the opcode control decoder.
- Captures the decoder's WB/M/EX control bundles together with the decode-stage operands each clock, and presents them to the execute stage.
- Supports stall (hold), flush (bubble insertion) and a saturating bubble counter for debug.

Parameters:
- DW, 32, width of the datapath fields (npc, read data 1/2, sign-extended immediate).
- CNTW, 16, width of the bubble counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- ctlwb_in  input  2  {RegWrite, MemToReg} from control.
- ctlm_in  input  3  {Branch, MemRead, MemWrite} from control.
- ctlex_in  input  4  {RegDst, ALUOp[1:0], ALUSrc} from control.
- npc_in  input  DW  PC+4 from IF/ID.
- readdat1_in  input  DW  register file port 1.
- readdat2_in  input  DW  register file port 2.
- signext_in  input  DW  sign-extended immediate.
- rs_in  input  5  instr[25:21].
- rt_in  input  5  instr[20:16].
- rd_in  input  5  instr[15:11].
- valid_in  input  1  decode slot holds a real instruction.
- stall  input  1  hold all registers.
- flush  input  1  replace the captured instruction with a bubble.
- wb_out  output  2  registered ctlwb.
- m_out  output  3  registered ctlm.
- ex_out  output  4  registered ctlex.
- npc_out  output  DW  registered npc.
- readdat1_out  output  DW  registered read data 1.
- readdat2_out  output  DW  registered read data 2.
- signext_out  output  DW  registered immediate.
- rs_out  output  5  registered rs.
- rt_out  output  5  registered rt.
- rd_out  output  5  registered rd.
- valid_out  output  1  registered valid.
- hazard_stall  output  1  load-use stall request to IF/ID and PC (see Optional Feature).
- bubble_cnt  output  CNTW  number of bubbles inserted since reset.

Behaviour:
- Reset: rst high clears every registered output and bubble_cnt to 0 immediately, without waiting for clk. Reset asserted mid-stall or mid-flush clears everything; the first edge after deassertion loads normally.
- Per-edge priority: rst > flush > internal hazard bubble > stall > load.
- Load: every output register takes its *_in value on the edge; latency is exactly 1 cycle.
- Flush or bubble:
  - wb_out, m_out, ex_out and valid_out become 0.
  - The data fields (npc, read data, immediate, rs/rt/rd) still load their inputs; they are don't-care once valid_out=0.
  - bubble_cnt increments by 1 and saturates at all-ones. It does not increment during stall or load.
- Stall, without flush or bubble: all registers hold, including valid_out.
- flush and stall asserted together: flush wins, so a bubble is inserted.
- Control fields are passed through unmodified; the block does no decoding.

Optional Feature:
- Macro: ID_EX_HAZARD_DETECT_EN.
- Defined:
  - hazard = valid_out & m_out[1] & valid_in & (rt_out==rs_in | rt_out==rt_in). This is a load-use hazard.
  - hazard_stall = hazard, combinational.
  - On an edge with hazard=1 and no flush, a bubble is loaded; this overrides external stall.
  - The following cycle, the EX slot holds a bubble, so hazard drops and the held decode instruction loads.
  - rt_out==0 still counts as a match.
- Undefined: hazard_stall tied to 0 and no internal bubble is inserted.

Test Plan:
- Reset: assert rst mid-cycle with nonzero outputs -> all outputs 0 before the next edge; bubble_cnt=0.
- R-type load: ctlwb=2'b10, ctlm=3'b000, ctlex=4'b1100, readdat1=32'h11, valid=1 -> next edge wb_out=2'b10, ex_out=4'b1100, readdat1_out=32'h11, valid_out=1.
- Stall: load lw controls (2'b11/3'b010/4'b0001), then stall=1 for 3 cycles while inputs change -> outputs hold the lw values; bubble_cnt unchanged.
- Flush with stall: flush=1 and stall=1 on the same edge -> wb/m/ex/valid_out=0 and bubble_cnt increments 0->1. Also drive 2^CNTW+2 flushes -> bubble_cnt saturates at all-ones.
- Load-use (macro defined): lw in EX with rt_out=5'd8, decode rs_in=5'd8 valid -> hazard_stall=1 in the same cycle; next edge produces a bubble (valid_out=0, bubble_cnt+1); hazard_stall=0 afterwards. Macro undefined, same stimulus -> hazard_stall=0 and the instruction loads.
